packet_rr_arbiter: RTL and testbench

- Packet-level round-robin arbiter that merges NI AXI-Stream packet sources onto one output stream.
- Sits upstream of the header-insertion stage, so that several producers share a single header-insertion path and its FIFO.
- Grants are held for a whole packet; packets are never interleaved.

---
 rtl/packet_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_packet_rr_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_rr_arbiter.sv
// Packet-level round-robin arbiter merging NI AXI-Stream sources onto one output stream.
// Optional per-source packet counters are enabled with the ARB_PKT_COUNT_EN macro.
module packet_rr_arbiter #(
   parameter  int DW = 128,
   parameter  int NI = 4,
   localparam int IW = $clog2(NI)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NI*DW-1:0]     s_axis_tdata,
   input  logic [NI*DW/8-1:0]   s_axis_tkeep,
   input  logic [NI-1:0]        s_axis_tlast,
   input  logic [NI-1:0]        s_axis_tvalid,
   output logic [NI-1:0]        s_axis_tready,
   output logic [DW-1:0]        m_axis_tdata,
   output logic [DW/8-1:0]      m_axis_tkeep,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [IW-1:0]        active_src,
   output logic                 busy
`ifdef ARB_PKT_COUNT_EN
   ,output logic [NI*32-1:0]    pkt_count
`endif
);

   localparam int KW = DW / 8;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t          state_r;
   logic [IW-1:0]   grant_r;
   logic [IW-1:0]   prio_ptr_r;
   logic [IW-1:0]   winner_s;
   logic            last_hs_s;

   // First requester found scanning upward from the slot after ptr, with wrap.
   function automatic logic [IW-1:0] next_winner(input logic [IW-1:0] ptr,
                                                 input logic [NI-1:0] req);
      logic [IW-1:0] win;
      logic          found;
      int            idx;
      win   = ptr;
      found = 1'b0;
      for (int k = 1; k <= NI; k++) begin
         idx = (int'(ptr) + k) % NI;
         if (!found && req[idx]) begin
            win   = IW'(idx);
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return win;
   endfunction

   assign winner_s  = next_winner(prio_ptr_r, s_axis_tvalid);
   assign last_hs_s = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // Output mux driven from the registered grant; forced quiet while reset is high.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
      busy          = 1'b0;
      active_src    = '0;
      if (reset) begin
         busy = 1'b0;
      end else if (state_r == ACTIVE) begin
         m_axis_tdata           = s_axis_tdata[int'(grant_r)*DW +: DW];
         m_axis_tkeep           = s_axis_tkeep[int'(grant_r)*KW +: KW];
         m_axis_tlast           = s_axis_tlast[grant_r];
         m_axis_tvalid          = s_axis_tvalid[grant_r];
         s_axis_tready[grant_r] = m_axis_tready;
         busy                   = 1'b1;
         active_src             = grant_r;
      end else begin
         active_src = grant_r;
      end
   end

   // Arbitration FSM: grant is captured in IDLE and held until the tlast handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         grant_r    <= '0;
         prio_ptr_r <= IW'(NI - 1);
      end else begin
         case (state_r)
            IDLE: begin
               if (|s_axis_tvalid) begin
                  grant_r    <= winner_s;
                  prio_ptr_r <= winner_s;
                  state_r    <= ACTIVE;
               end else begin
                  state_r    <= IDLE;
               end
            end
            ACTIVE: begin
               if (last_hs_s) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= ACTIVE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

`ifdef ARB_PKT_COUNT_EN
   logic [31:0] pkt_cnt_r [NI];

   // Per-source completed-packet counters; wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NI; i++) begin
            pkt_cnt_r[i] <= 32'd0;
         end
      end else if (last_hs_s) begin
         pkt_cnt_r[grant_r] <= pkt_cnt_r[grant_r] + 32'd1;
      end else begin
         pkt_cnt_r[grant_r] <= pkt_cnt_r[grant_r];
      end
   end

   for (genvar g = 0; g < NI; g++) begin : g_cnt
      assign pkt_count[g*32 +: 32] = pkt_cnt_r[g];
   end
`endif

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Directed self-checking bench for packet_rr_arbiter (DW=128, NI=4).
module tb_packet_rr_arbiter;

   localparam int DW = 128;
   localparam int NI = 4;
   localparam int KW = DW / 8;
   localparam int IW = 2;

   logic                clk = 1'b0;
   logic                reset;
   logic [NI*DW-1:0]    s_tdata;
   logic [NI*KW-1:0]    s_tkeep;
   logic [NI-1:0]       s_tlast;
   logic [NI-1:0]       s_tvalid;
   logic [NI-1:0]       s_tready;
   logic [DW-1:0]       m_tdata;
   logic [KW-1:0]       m_tkeep;
   logic                m_tlast;
   logic                m_tvalid;
   logic                m_tready;
   logic [IW-1:0]       active_src;
   logic                busy;
`ifdef ARB_PKT_COUNT_EN
   logic [NI*32-1:0]    pkt_count;
`endif

   logic [DW-1:0] sd [NI];
   logic [KW-1:0] sk [NI];
   logic [NI-1:0] sv;
   logic [NI-1:0] sl;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NI; i++) begin
         s_tdata[i*DW +: DW] = sd[i];
         s_tkeep[i*KW +: KW] = sk[i];
      end
      s_tvalid = sv;
      s_tlast  = sl;
   end

   packet_rr_arbiter #(.DW(DW), .NI(NI)) dut (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .active_src(active_src), .busy(busy)
`ifdef ARB_PKT_COUNT_EN
      ,.pkt_count(pkt_count)
`endif
   );

   function automatic logic [DW-1:0] mk_data(input int src, input int pkt, input int beat);
      return {4{8'(src), 8'(pkt), 8'(beat), 8'hC3}};
   endfunction

   function automatic logic [KW-1:0] mk_keep(input int src, input int beat);
      return {4'(src + 1), 4'(beat), 8'hA5};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic v, input int pkt, input int beat, input logic last);
      sv[i] = v;
      sd[i] = mk_data(i, pkt, beat);
      sk[i] = mk_keep(i, beat);
      sl[i] = last;
   endtask

   task automatic apply_reset();
      reset    = 1'b1;
      sv       = 4'b0000;
      sl       = 4'b0000;
      m_tready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      m_tready = 1'b1;
      for (int i = 0; i < NI; i++) set_src(i, 1'b1, 0, 0, 1'b1);
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0 || s_tready !== 4'b0000 || busy !== 1'b0 ||
          active_src !== 2'd0 || m_tdata !== {DW{1'b0}} || m_tlast !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: tvalid=%b tready=%b busy=%b src=%0d last=%b required all 0",
                  m_tvalid, s_tready, busy, active_src, m_tlast);
      end
      tick();
      reset = 1'b0;
      sv    = 4'b0000;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (m_tvalid !== 1'b0 || s_tready !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_c%0d: tvalid=%b tready=%b busy=%b required 0,0000,0",
                     c, m_tvalid, s_tready, busy);
         end
         tick();
      end
   endtask

   task automatic test_single_src();
      apply_reset();
      set_src(2, 1'b1, 0, 0, 1'b0);
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_arb_cycle: tvalid=%b busy=%b required 0,0", m_tvalid, busy);
      end
      tick();
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         checks++;
         if (m_tvalid !== 1'b1 || active_src !== 2'd2 || busy !== 1'b1 ||
             m_tdata !== mk_data(2, 0, b) || m_tkeep !== mk_keep(2, b) ||
             m_tlast !== (b == 2) || s_tready !== 4'b0100) begin
            failures++;
            $display("FAIL single_beat%0d: tvalid=%b src=%0d last=%b data=%h tready=%b required 1,2,%0d,%h,0100",
                     b, m_tvalid, active_src, m_tlast, m_tdata, s_tready, (b == 2), mk_data(2, 0, b));
         end
         tick();
         if (b < 2) set_src(2, 1'b1, 0, b + 1, (b + 1) == 2);
         else       sv[2] = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL single_busy_drop: busy=%b tvalid=%b required 0,0", busy, m_tvalid);
      end
   endtask

   task automatic test_all_valid();
      int   beat [NI];
      int   pkt  [NI];
      int   npkt [NI];
      int   order [5];
      int   done;
      logic gap_due;
      logic hs [NI];
      npkt  = '{2, 1, 1, 1};
      order = '{0, 1, 2, 3, 0};
      done    = 0;
      gap_due = 1'b0;
      apply_reset();
      for (int i = 0; i < NI; i++) begin
         beat[i] = 0;
         pkt[i]  = 0;
         set_src(i, 1'b1, 0, 0, 1'b0);
      end
      for (int c = 0; c < 60 && done < 5; c++) begin
         @(negedge clk);
         if (gap_due) begin
            checks++;
            if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
               failures++;
               $display("FAIL rr_gap_pkt%0d: tvalid=%b busy=%b required 0,0", done, m_tvalid, busy);
            end
            gap_due = 1'b0;
         end else if (m_tvalid === 1'b1) begin
            checks++;
            if (active_src !== IW'(order[done]) ||
                m_tdata !== mk_data(order[done], pkt[order[done]], beat[order[done]]) ||
                m_tkeep !== mk_keep(order[done], beat[order[done]]) ||
                m_tlast !== (beat[order[done]] == 1) || s_tready !== (4'b0001 << order[done])) begin
               failures++;
               $display("FAIL rr_pkt%0d: src=%0d data=%h keep=%h tready=%b required src=%0d data=%h keep=%h",
                        done, active_src, m_tdata, m_tkeep, s_tready, order[done],
                        mk_data(order[done], pkt[order[done]], beat[order[done]]),
                        mk_keep(order[done], beat[order[done]]));
            end
         end
         for (int i = 0; i < NI; i++) hs[i] = s_tready[i] & sv[i];
         tick();
         for (int i = 0; i < NI; i++) begin
            if (hs[i]) begin
               if (beat[i] == 1) begin
                  gap_due = 1'b1;
                  done++;
                  pkt[i]++;
                  beat[i] = 0;
                  if (pkt[i] >= npkt[i]) sv[i] = 1'b0;
                  else                   set_src(i, 1'b1, pkt[i], 0, 1'b0);
               end else begin
                  beat[i] = 1;
                  set_src(i, 1'b1, pkt[i], 1, 1'b1);
               end
            end
         end
      end
      checks++;
      if (done != 5) begin
         failures++;
         $display("FAIL rr_complete: packets=%0d required 5", done);
      end
      sv = 4'b0000;
   endtask

   task automatic test_backpressure();
      logic [7:0] pat;
      int   beat;
      int   nhs;
      logic hs;
      pat  = 8'b0110_1001;
      beat = 0;
      nhs  = 0;
      apply_reset();
      set_src(1, 1'b1, 0, 0, 1'b0);
      tick();
      set_src(0, 1'b1, 9, 9, 1'b1);
      for (int c = 0; c < 12 && beat < 4; c++) begin
         m_tready = pat[c % 8];
         @(negedge clk);
         checks++;
         if (m_tvalid !== 1'b1 || active_src !== 2'd1 || m_tdata !== mk_data(1, 0, beat) ||
             m_tlast !== (beat == 3) || s_tready !== (m_tready ? 4'b0010 : 4'b0000)) begin
            failures++;
            $display("FAIL bp_c%0d: tvalid=%b src=%0d data=%h tready=%b required 1,1,%h,%b",
                     c, m_tvalid, active_src, m_tdata, s_tready, mk_data(1, 0, beat),
                     (m_tready ? 4'b0010 : 4'b0000));
         end
         hs = m_tvalid & m_tready & s_tready[1];
         tick();
         if (hs) begin
            nhs++;
            beat++;
            if (beat == 4) sv[1] = 1'b0;
            else           set_src(1, 1'b1, 0, beat, beat == 3);
         end
      end
      sv[0]    = 1'b0;
      m_tready = 1'b1;
      checks++;
      if (nhs != 4) begin
         failures++;
         $display("FAIL bp_handshakes: count=%0d required 4", nhs);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL bp_end_idle: busy=%b tvalid=%b required 0,0", busy, m_tvalid);
      end
   endtask

   task automatic test_stall_hold();
      apply_reset();
      set_src(1, 1'b1, 0, 0, 1'b1);
      tick();
      sv[1] = 1'b0;
      set_src(2, 1'b1, 0, 0, 1'b1);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || m_tvalid !== 1'b0 || active_src !== 2'd1 || s_tready !== 4'b0010) begin
            failures++;
            $display("FAIL stall_hold_c%0d: busy=%b tvalid=%b src=%0d tready=%b required 1,0,1,0010",
                     c, busy, m_tvalid, active_src, s_tready);
         end
         tick();
      end
      sv[1] = 1'b1;
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== mk_data(1, 0, 0) || active_src !== 2'd1) begin
         failures++;
         $display("FAIL stall_resume: tvalid=%b src=%0d data=%h required 1,1,%h",
                  m_tvalid, active_src, m_tdata, mk_data(1, 0, 0));
      end
      tick();
      sv[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL stall_dead_cycle: busy=%b required 0", busy);
      end
      tick();
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b1 || active_src !== 2'd2 || m_tdata !== mk_data(2, 0, 0)) begin
         failures++;
         $display("FAIL stall_next_src: tvalid=%b src=%0d required 1,2", m_tvalid, active_src);
      end
      tick();
      sv = 4'b0000;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      set_src(3, 1'b1, 0, 0, 1'b1);
      tick();
      for (int p = 0; p < 2; p++) begin
         @(negedge clk);
         checks++;
         if (m_tvalid !== 1'b1 || m_tlast !== 1'b1 || active_src !== 2'd3 || m_tdata !== mk_data(3, p, 0)) begin
            failures++;
            $display("FAIL b2b_pkt%0d: tvalid=%b last=%b src=%0d data=%h required 1,1,3,%h",
                     p, m_tvalid, m_tlast, active_src, m_tdata, mk_data(3, p, 0));
         end
         tick();
         if (p == 0) set_src(3, 1'b1, 1, 0, 1'b1);
         else        sv[3] = 1'b0;
         @(negedge clk);
         checks++;
         if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap%0d: tvalid=%b busy=%b required 0,0", p, m_tvalid, busy);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_packet();
      apply_reset();
      set_src(3, 1'b1, 0, 0, 1'b0);
      tick();
      @(negedge clk);
      tick();
      set_src(3, 1'b1, 0, 1, 1'b0);
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b1 || active_src !== 2'd3 || m_tdata !== mk_data(3, 0, 1)) begin
         failures++;
         $display("FAIL rmid_beat2: tvalid=%b src=%0d required 1,3", m_tvalid, active_src);
      end
      tick();
      reset = 1'b1;
      set_src(3, 1'b1, 0, 2, 1'b0);
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0 || s_tready !== 4'b0000 || busy !== 1'b0 ||
          active_src !== 2'd0 || m_tdata !== {DW{1'b0}} || m_tkeep !== {KW{1'b0}}) begin
         failures++;
         $display("FAIL rmid_forced_zero: tvalid=%b tready=%b busy=%b src=%0d required all 0",
                  m_tvalid, s_tready, busy, active_src);
      end
      tick();
      reset = 1'b0;
      set_src(0, 1'b1, 0, 0, 1'b1);
      set_src(3, 1'b1, 1, 0, 1'b1);
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rmid_idle: tvalid=%b busy=%b required 0,0", m_tvalid, busy);
      end
      tick();
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b1 || active_src !== 2'd0 || m_tdata !== mk_data(0, 0, 0)) begin
         failures++;
         $display("FAIL rmid_src0_wins: tvalid=%b src=%0d required 1,0", m_tvalid, active_src);
      end
      tick();
      sv = 4'b0000;
   endtask

`ifdef ARB_PKT_COUNT_EN
   task automatic send_single(input int src, input int pkt);
      int done;
      done = 0;
      set_src(src, 1'b1, pkt, 0, 1'b1);
      for (int c = 0; c < 10 && done == 0; c++) begin
         @(negedge clk);
         if (m_tvalid === 1'b1 && s_tready[src] === 1'b1) done = 1;
         tick();
      end
      sv[src] = 1'b0;
      checks++;
      if (done == 0) begin
         failures++;
         $display("FAIL cnt_send_src%0d: no handshake within 10 cycles", src);
      end
      tick();
   endtask

   task automatic test_pkt_count();
      apply_reset();
      send_single(1, 0);
      send_single(1, 1);
      send_single(0, 0);
      send_single(1, 2);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (pkt_count[i*32 +: 32] !== ((i == 1) ? 32'd3 : (i == 0) ? 32'd1 : 32'd0)) begin
            failures++;
            $display("FAIL pkt_count%0d: got %0d required %0d", i, pkt_count[i*32 +: 32],
                     (i == 1) ? 3 : (i == 0) ? 1 : 0);
         end
      end
   endtask
`endif

   initial begin
      reset    = 1'b1;
      m_tready = 1'b1;
      sv       = 4'b0000;
      sl       = 4'b0000;
      for (int i = 0; i < NI; i++) begin
         sd[i] = {DW{1'b0}};
         sk[i] = {KW{1'b0}};
      end
      test_reset();
      test_single_src();
      test_all_valid();
      test_backpressure();
      test_stall_hold();
      test_back_to_back();
      test_reset_mid_packet();
`ifdef ARB_PKT_COUNT_EN
      test_pkt_count();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
